// File: rtl/xbar_receiver_arbiter_if.sv
// Request/handshake/grant bundle between one crossbar receiver column and its arbiter.
// The arbiter sits on the slave side; the crossbar column logic drives the master side.
interface xbar_receiver_arbiter_if #(
  parameter int SENDER_NUM = 8,
  parameter int MAX_BEATS  = 256
);
  localparam int IDX_W = $clog2(SENDER_NUM);
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  logic [SENDER_NUM-1:0] req;
  logic                  valid_in;
  logic                  ready_in;
  logic                  last_in;
  logic [SENDER_NUM-1:0] grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  busy;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  proto_err;

  modport master (
    output req, valid_in, ready_in, last_in,
    input  grant, grant_idx, busy, beat_cnt, proto_err
  );

  modport slave (
    input  req, valid_in, ready_in, last_in,
    output grant, grant_idx, busy, beat_cnt, proto_err
  );
endinterface

// File: rtl/xbar_receiver_arbiter.sv
// Per-receiver round-robin arbiter: holds a one-hot sender grant for a whole burst,
// releases on the last-beat handshake and hands off to the next requester without a bubble.
//
// state   | meaning
// IDLE    | no grant held; arbitrate over req from ptr
// GRANTED | grant frozen until a handshake with last_in=1
module xbar_receiver_arbiter #(
  parameter int SENDER_NUM      = 8,
  parameter int RECEIVER_CHOSEN = 1,
  parameter int MAX_BEATS       = 256
) (
  input logic                   clk,
  input logic                   rst,
  xbar_receiver_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(SENDER_NUM);
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  if (SENDER_NUM < 2 || RECEIVER_CHOSEN < 0) begin : g_bad_param
    $error("xbar_receiver_arbiter: SENDER_NUM must be >= 2 and RECEIVER_CHOSEN >= 0");
  end

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                state_q, state_d;
  logic [SENDER_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;

  logic [IDX_W-1:0]      ptr_rel;
  logic [IDX_W-1:0]      arb_ptr;
  logic [SENDER_NUM-1:0] arb_req;
  logic                  arb_found;
  logic [IDX_W-1:0]      arb_idx;
  logic                  hs;

  assign hs      = bus.valid_in & bus.ready_in;
  assign ptr_rel = (idx_q == IDX_W'(SENDER_NUM-1)) ? '0 : idx_q + 1'b1;

  // On release the search starts after the releasing sender, which is masked out.
  assign arb_ptr = (state_q == GRANTED) ? ptr_rel : ptr_q;
  assign arb_req = (state_q == GRANTED) ? (bus.req & ~grant_q) : bus.req;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = SENDER_NUM-1; k >= 0; k--) begin
      int s;
      s = int'(arb_ptr) + k;
      if (s >= SENDER_NUM) s = s - SENDER_NUM;
      if (arb_req[IDX_W'(s)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(s);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = SENDER_NUM'(1) << arb_idx;
          idx_d   = arb_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (hs && bus.last_in) begin
          ptr_d = ptr_rel;
          cnt_d = '0;
          if (arb_found) begin
            grant_d = SENDER_NUM'(1) << arb_idx;
            idx_d   = arb_idx;
          end else begin
            grant_d = '0;
            idx_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (hs) begin
          if (cnt_q == CNT_W'(MAX_BEATS-1)) err_d = 1'b1;
          if (cnt_q != CNT_W'(MAX_BEATS)) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy_q;
  assign bus.beat_cnt  = cnt_q;
  assign bus.proto_err = err_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_busy:   assert property (@(posedge clk) disable iff (rst) busy_q == (|grant_q));
  a_idx:    assert property (@(posedge clk) disable iff (rst) (grant_q == '0) || grant_q[idx_q]);
endmodule

// File: tb/tb_xbar_receiver_arbiter.sv
// Directed bench: stimulus queues expected grants; a negedge monitor checks each new grant.
module tb_xbar_receiver_arbiter;
  localparam int N  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xbar_receiver_arbiter_if #(.SENDER_NUM(N), .MAX_BEATS(MB)) bus ();

  xbar_receiver_arbiter #(.SENDER_NUM(N), .RECEIVER_CHOSEN(1), .MAX_BEATS(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input logic [7:0] g, input logic [2:0] i);
    exp_t e;
    e.g = g;
    e.i = i;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // A new grant is either a rise from zero or whatever follows a last-beat handshake.
  logic [7:0] prev_g  = '0;
  logic       rel_pend = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_g   = '0;
      rel_pend = 1'b0;
    end else begin
      if (bus.grant != 0 && (prev_g == 0 || rel_pend)) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: actual grant=%0h required none at %0t", bus.grant, $time);
        end else begin
          e = q.pop_front();
          chk("sb_grant", 32'(bus.grant), 32'(e.g));
          chk("sb_idx", 32'(bus.grant_idx), 32'(e.i));
        end
      end
      prev_g   = bus.grant;
      rel_pend = bus.busy & bus.valid_in & bus.ready_in & bus.last_in;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0; bus.valid_in = 0; bus.ready_in = 0; bus.last_in = 0;
    cyc(); cyc();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_idx", 32'(bus.grant_idx), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_beat", 32'(bus.beat_cnt), 0);
    chk("rst_err", 32'(bus.proto_err), 0);
    rst = 0;

    // single beat to sender 2, then ptr=3 preference check
    bus.req = 8'h04; bus.valid_in = 1; bus.ready_in = 1; bus.last_in = 1;
    push(8'h04, 3'd2);
    cyc();
    chk("t1_grant", 32'(bus.grant), 32'h04);
    bus.req = '0;
    cyc();
    chk("t1_release_grant", 32'(bus.grant), 0);
    chk("t1_release_busy", 32'(bus.busy), 0);
    bus.req = 8'h0C;
    push(8'h08, 3'd3);
    cyc();
    bus.req = '0;
    cyc();
    chk("t1b_idle", 32'(bus.busy), 0);

    // all senders, single-beat bursts, no bubbles
    rst = 1; cyc(); rst = 0;
    bus.req = 8'hFF;
    for (int i = 0; i < 9; i++) push(8'(1 << (i % 8)), 3'(i % 8));
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("t2_busy", 32'(bus.busy), 1);
    end
    bus.req = '0;
    cyc();
    chk("t2_idle", 32'(bus.busy), 0);

    // sender 5 four-beat burst with ready toggling, req changes mid-burst
    bus.req = 8'h20; bus.valid_in = 0; bus.ready_in = 0; bus.last_in = 0;
    push(8'h20, 3'd5); push(8'h40, 3'd6); push(8'h02, 3'd1);
    cyc();
    chk("t3_grant", 32'(bus.grant), 32'h20);
    bus.req = 8'h42; bus.valid_in = 1;
    for (int k = 0; k < 7; k++) begin
      bus.ready_in = (k % 2 == 0);
      bus.last_in  = (k == 6);
      cyc();
      if (k < 6) chk("t3_hold", 32'(bus.grant), 32'h20);
      if (k == 4) chk("t3_beat", 32'(bus.beat_cnt), 3);
    end
    chk("t3_err", 32'(bus.proto_err), 0);
    cyc();
    bus.req = '0;
    cyc();
    chk("t3_idle", 32'(bus.busy), 0);

    // reset mid-burst
    bus.req = 8'h08; bus.valid_in = 0; bus.ready_in = 1; bus.last_in = 0;
    push(8'h08, 3'd3);
    cyc();
    chk("t4_grant", 32'(bus.grant), 32'h08);
    bus.valid_in = 1; bus.req = 8'h09;
    cyc();
    chk("t4_beat1", 32'(bus.beat_cnt), 1);
    rst = 1; bus.last_in = 1;
    cyc();
    chk("t4_rst_grant", 32'(bus.grant), 0);
    chk("t4_rst_beat", 32'(bus.beat_cnt), 0);
    chk("t4_rst_busy", 32'(bus.busy), 0);
    rst = 0;
    push(8'h01, 3'd0);
    cyc();
    bus.req = '0;
    cyc();
    chk("t4_idle", 32'(bus.busy), 0);

    // only sender 7: bubble between re-grants, ptr wraps to 0
    bus.req = 8'h80; bus.valid_in = 1; bus.ready_in = 1; bus.last_in = 1;
    push(8'h80, 3'd7); push(8'h80, 3'd7);
    cyc();
    chk("t5_grant_a", 32'(bus.grant), 32'h80);
    cyc();
    chk("t5_bubble", 32'(bus.busy), 0);
    cyc();
    chk("t5_grant_b", 32'(bus.grant), 32'h80);
    chk("t5_idx_b", 32'(bus.grant_idx), 7);
    bus.req = '0;
    cyc();
    bus.req = 8'h81;
    push(8'h01, 3'd0);
    cyc();
    bus.req = '0;
    cyc();
    chk("t5_idle", 32'(bus.busy), 0);

    // overlong burst with MAX_BEATS=4
    bus.req = 8'h01; bus.valid_in = 0; bus.ready_in = 1; bus.last_in = 0;
    push(8'h01, 3'd0);
    cyc();
    bus.valid_in = 1; bus.req = '0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("t6_err", 32'(bus.proto_err), (k >= 4) ? 1 : 0);
      chk("t6_beat", 32'(bus.beat_cnt), (k >= 4) ? 4 : k);
      chk("t6_hold", 32'(bus.grant), 32'h01);
    end
    bus.last_in = 1;
    cyc();
    chk("t6_release", 32'(bus.busy), 0);
    chk("t6_err_sticky", 32'(bus.proto_err), 1);
    bus.valid_in = 0;
    rst = 1;
    cyc();
    chk("t6_err_clr", 32'(bus.proto_err), 0);
    rst = 0;
    cyc(); cyc();
    chk("sb_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
